spi_slave: RTL

SPI responder (slave) for the FPGA test fabric: the target-side counterpart of the team's SPI master, sharing its frame format. 8-bit frames, LSB first, all four CPOL/CPHA modes. The external `sclk`/`ss`/`mosi` are oversampled in the system clock domain. Received bytes go out as a one-cycle `rx_valid` pulse; bytes to send come from a single-entry transmit buffer with a ready/load handshake.

---
 rtl/spi_slave.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// SPI responder: 8-bit LSB-first frames, all CPOL/CPHA modes, with the SPI pins
// oversampled in the clk domain and a single-entry transmit buffer.
//
// state | meaning
// IDLE  | not selected; sclk edges ignored; waits for an ss fall
// SHIFT | selected; sampling mosi and shifting miso on sclk edges
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic       cpol,
    input  logic       cpha,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic       tx_underrun,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic       sclk_d, ss_d, armed;
    logic       sclk_s, ss_s, mosi_s;
    logic       sclk_edge, ss_fall, ss_rise;
    logic       lead, trail, sample_pt, shift_pt, load_now;
    logic       cpol_l, cpha_l, need_load, tx_full;
    logic [2:0] bit_cnt;
    logic [7:0] shreg, rx_sh, tx_buf, ld_val, src;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // ss must be seen high after reset before a fall counts, so an ss held
    // low across reset release is not mistaken for a new selection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
            if (ss_s)
                armed <= 1'b1;
        end
    end

    assign sclk_edge = sclk_s ^ sclk_d;
    assign ss_fall   = armed & ss_d & ~ss_s;
    assign ss_rise   = ~ss_d & ss_s;

    assign lead      = (state == SHIFT) && sclk_edge && (sclk_s != cpol_l) && !ss_rise;
    assign trail     = (state == SHIFT) && sclk_edge && (sclk_s == cpol_l) && !ss_rise;
    assign sample_pt = cpha_l ? trail : lead;
    assign shift_pt  = cpha_l ? lead : trail;
    assign load_now  = ((state == IDLE) && ss_fall) || (shift_pt && need_load);
    assign ld_val    = tx_full ? tx_buf : 8'h00;
    assign src       = need_load ? ld_val : shreg;

    assign tx_ready  = ~tx_full;
    assign busy      = (state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ss_fall) state_nx = SHIFT;
            SHIFT:   if (ss_rise) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            tx_underrun <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            cpol_l      <= 1'b0;
            cpha_l      <= 1'b0;
            need_load   <= 1'b0;
            tx_full     <= 1'b0;
            tx_buf      <= 8'h00;
            bit_cnt     <= 3'd0;
            shreg       <= 8'h00;
            rx_sh       <= 8'h00;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            miso_oe     <= armed & ~ss_s;

            if (tx_load && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
            // A load from an empty buffer sends 0x00; a same-cycle tx_load
            // still lands in the buffer above for the following byte.
            if (load_now) begin
                if (tx_full)
                    tx_full <= 1'b0;
                else
                    tx_underrun <= 1'b1;
            end

            if ((state == IDLE) && ss_fall) begin
                cpol_l    <= cpol;
                cpha_l    <= cpha;
                bit_cnt   <= 3'd0;
                need_load <= 1'b0;
                if (cpha) begin
                    shreg <= ld_val;
                end else begin
                    shreg <= {1'b0, ld_val[7:1]};
                    miso  <= ld_val[0];
                end
            end else if (state == SHIFT) begin
                if (ss_rise) begin
                    bit_cnt   <= 3'd0;
                    need_load <= 1'b0;
                    miso      <= 1'b0;
                end else begin
                    if (shift_pt) begin
                        miso      <= src[0];
                        shreg     <= {1'b0, src[7:1]};
                        need_load <= 1'b0;
                    end
                    if (sample_pt) begin
                        rx_sh   <= {mosi_s, rx_sh[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data   <= {mosi_s, rx_sh[7:1]};
                            rx_valid  <= 1'b1;
                            need_load <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
